// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [ADDR_W-1:0]  PC_STEP   = 32'd4;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    // One buffered fetch result: the word and the byte address it came from.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

    // Force a byte address onto a word boundary.
    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
        return {pc[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO holding returned instruction words until decode takes them.
// Flush empties the buffer in one cycle; storage is cleared only by reset so the
// head reads as zero out of reset.
import fetch_pkg::*;

module fetch_buffer #(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic [CW-1:0] count_o,
    output fetch_entry_t head_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Storage, pointers and occupancy; flush wins over push/pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop_i) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push_i && !pop_i) begin
                count_q <= count_q + CW'(1);
            end else if (!push_i && pop_i) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues one word read per cycle
// to a one-cycle-latency memory, buffers returns and hands them to decode.
// Optional build macro FETCH_MISALIGN_CHECK_EN: misaligned redirects raise a sticky
// fetch_fault and stop issue; without it redirect targets are word-aligned.
import fetch_pkg::*;

module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_read_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        fetch_fault
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    logic [ADDR_W-1:0] f_pc_q, f_pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              fault_q, fault_d;

    logic [ADDR_W-1:0] redir_pc;
    logic              redir_misaligned;
    logic              pop;
    logic              push;
    logic              issue;
    logic [CW-1:0]     count;
    logic [CW:0]       occupancy;
    fetch_entry_t      head;
    fetch_entry_t      push_entry;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign redir_pc         = redirect_pc;
    assign redir_misaligned = (redirect_pc[1:0] != 2'b00);
`else
    assign redir_pc         = align_pc(redirect_pc);
    assign redir_misaligned = 1'b0;
`endif

    assign pop  = instr_valid & instr_ready;
    assign push = inflight_q & ~redirect_valid;

    // Entries that will be buffered or still owed by memory after this cycle's pop.
    assign occupancy = {1'b0, count} - (CW + 1)'(pop) + (CW + 1)'(inflight_q);
    assign issue     = ~redirect_valid & ~fault_q & (occupancy < DEPTH_C);

    // PC / in-flight tracking next state; redirect has priority over issue.
    always_comb begin
        f_pc_d        = f_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        fault_d       = fault_q;
        if (redirect_valid) begin
            f_pc_d  = redir_pc;
            fault_d = redir_misaligned;
        end else if (issue) begin
            inflight_d    = 1'b1;
            inflight_pc_d = f_pc_q;
            f_pc_d        = f_pc_q + PC_STEP;
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f_pc_q        <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            fault_q       <= 1'b0;
        end else begin
            f_pc_q        <= f_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            fault_q       <= fault_d;
        end
    end

    assign push_entry.instr = imem_read_data;
    assign push_entry.pc    = inflight_pc_q;

    fetch_buffer #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_buffer (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .flush_i     (redirect_valid),
        .count_o     (count),
        .head_o      (head)
    );

    assign imem_address = f_pc_q;
    assign instr_valid  = (count != '0);
    assign instr        = head.instr;
    assign instr_pc     = head.pc;
    assign fetch_fault  = fault_q;

endmodule
